// File: rtl/spi_master_if.sv
// spi_master_if: command/read-data handshake between a host and the SPI master.
interface spi_master_if;
  logic       cmd_valid;
  logic [9:0] cmd_data;
  logic       cmd_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  modport master (output cmd_valid, cmd_data, input cmd_ready, rd_data, rd_valid, busy);
  modport slave  (input cmd_valid, cmd_data, output cmd_ready, rd_data, rd_valid, busy);
endinterface

// File: rtl/spi_master.sv
// spi_master: serializes 10-bit commands MSB first and, for rd-data frames, receives one byte after a turnaround.
module spi_master #(
  parameter int TURNAROUND = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.slave  bus,
  output logic         SS_n,
  output logic         MOSI,
  input  logic         MISO
);
  typedef enum logic [2:0] {IDLE, SEL, SHIFT, TURN, RECV, GAP} state_t;
  state_t      state;
  logic [9:0]  cmd;
  logic        rd;
  logic [3:0]  cnt;
  logic [7:0]  sr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cmd           <= '0;
      rd            <= 1'b0;
      cnt           <= '0;
      sr            <= '0;
      SS_n          <= 1'b1;
      MOSI          <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= '0;
    end else begin
      bus.rd_valid <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          state         <= SEL;
          cmd           <= bus.cmd_data;
          rd            <= &bus.cmd_data[9:8];
          cnt           <= '0;
          SS_n          <= 1'b0;
          MOSI          <= bus.cmd_data[9];
          bus.cmd_ready <= 1'b0;
          bus.busy      <= 1'b1;
        end
        SEL: begin
          state <= SHIFT;
          cnt   <= '0;
          MOSI  <= cmd[9];
        end
        // cmd shifts left so bit 8 always holds the next bit to send
        SHIFT: if (cnt == 4'd9) begin
          MOSI <= 1'b0;
          cnt  <= '0;
          if (!rd) begin
            state <= GAP;
            SS_n  <= 1'b1;
          end else if (TURNAROUND == 0) begin
            state <= RECV;
            sr    <= {sr[6:0], MISO};
          end else begin
            state <= TURN;
          end
        end else begin
          MOSI <= cmd[8];
          cmd  <= {cmd[8:0], 1'b0};
          cnt  <= cnt + 4'd1;
        end
        TURN: if ({1'b0, cnt} + 5'd1 == 5'(TURNAROUND)) begin
          state <= RECV;
          cnt   <= '0;
          sr    <= {sr[6:0], MISO};
        end else begin
          cnt <= cnt + 4'd1;
        end
        // first sample was taken on entry; cnt 0..6 are samples 2..8, cnt 7 holds SS_n low one more cycle
        RECV: begin
          sr <= {sr[6:0], MISO};
          if (cnt == 4'd6) begin
            bus.rd_data  <= {sr[6:0], MISO};
            bus.rd_valid <= 1'b1;
          end
          if (cnt == 4'd7) begin
            state <= GAP;
            SS_n  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        GAP: begin
          state         <= IDLE;
          cnt           <= '0;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
